// File: rtl/demux_pkg.sv
// Shared widths and types for the registered 1:16 demultiplexer.
// Select width and output count are tied together here so they cannot drift.
package demux_pkg;
    localparam int SEL_WIDTH   = 4;
    localparam int NUM_OUTPUTS = 16;

    typedef logic [SEL_WIDTH-1:0] demux_sel_t;
endpackage

// File: rtl/demux_1_16_sync_if.sv
// Routing bundle for demux_1_16_sync: enable/select/data in, sixteen routed outputs.
// slave is the demux side, master is the producer/consumer side.
interface demux_1_16_sync_if #(
    parameter int DATA_WIDTH = 1
) ();
    import demux_pkg::*;

    logic                  Enable_In;
    logic [DATA_WIDTH-1:0] Data_In;
    demux_sel_t            Select_In;

    logic [DATA_WIDTH-1:0] Data_0_Out;
    logic [DATA_WIDTH-1:0] Data_1_Out;
    logic [DATA_WIDTH-1:0] Data_2_Out;
    logic [DATA_WIDTH-1:0] Data_3_Out;
    logic [DATA_WIDTH-1:0] Data_4_Out;
    logic [DATA_WIDTH-1:0] Data_5_Out;
    logic [DATA_WIDTH-1:0] Data_6_Out;
    logic [DATA_WIDTH-1:0] Data_7_Out;
    logic [DATA_WIDTH-1:0] Data_8_Out;
    logic [DATA_WIDTH-1:0] Data_9_Out;
    logic [DATA_WIDTH-1:0] Data_10_Out;
    logic [DATA_WIDTH-1:0] Data_11_Out;
    logic [DATA_WIDTH-1:0] Data_12_Out;
    logic [DATA_WIDTH-1:0] Data_13_Out;
    logic [DATA_WIDTH-1:0] Data_14_Out;
    logic [DATA_WIDTH-1:0] Data_15_Out;

    modport slave (
        input  Enable_In, Data_In, Select_In,
        output Data_0_Out,  Data_1_Out,  Data_2_Out,  Data_3_Out,
               Data_4_Out,  Data_5_Out,  Data_6_Out,  Data_7_Out,
               Data_8_Out,  Data_9_Out,  Data_10_Out, Data_11_Out,
               Data_12_Out, Data_13_Out, Data_14_Out, Data_15_Out
    );

    modport master (
        output Enable_In, Data_In, Select_In,
        input  Data_0_Out,  Data_1_Out,  Data_2_Out,  Data_3_Out,
               Data_4_Out,  Data_5_Out,  Data_6_Out,  Data_7_Out,
               Data_8_Out,  Data_9_Out,  Data_10_Out, Data_11_Out,
               Data_12_Out, Data_13_Out, Data_14_Out, Data_15_Out
    );
endinterface

// File: rtl/decoder_4_16.sv
// Combinational 4-to-16 one-hot decoder; all lines low when en_i is low.
// Zero latency, no backpressure.
module decoder_4_16
    import demux_pkg::*;
(
    input  demux_sel_t             sel_i,
    input  logic                   en_i,
    output logic [NUM_OUTPUTS-1:0] line_o
);
    always_comb begin
        line_o = '0;
        if (en_i) begin
            line_o[sel_i] = 1'b1;
        end
    end
endmodule

// File: rtl/demux_1_16_sync.sv
// Registered 1:16 demux: Data_In steered to output[Select_In], all others zero.
// Latency 1 clock, outputs come straight from flops; no handshake, no backpressure.
module demux_1_16_sync
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic              Clock_In,
    input  logic              Reset_N_In,
    demux_1_16_sync_if.slave  bus
);
    logic [NUM_OUTPUTS-1:0] line;
    logic [DATA_WIDTH-1:0]  out_d [NUM_OUTPUTS];
    logic [DATA_WIDTH-1:0]  out_q [NUM_OUTPUTS];

    decoder_4_16 u_decoder (
        .sel_i  (bus.Select_In),
        .en_i   (bus.Enable_In),
        .line_o (line)
    );

    // Gating every line with the data keeps the vector one-hot-or-zero by construction.
    always_comb begin
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            out_d[k] = {DATA_WIDTH{line[k]}} & bus.Data_In;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    assign bus.Data_0_Out  = out_q[0];
    assign bus.Data_1_Out  = out_q[1];
    assign bus.Data_2_Out  = out_q[2];
    assign bus.Data_3_Out  = out_q[3];
    assign bus.Data_4_Out  = out_q[4];
    assign bus.Data_5_Out  = out_q[5];
    assign bus.Data_6_Out  = out_q[6];
    assign bus.Data_7_Out  = out_q[7];
    assign bus.Data_8_Out  = out_q[8];
    assign bus.Data_9_Out  = out_q[9];
    assign bus.Data_10_Out = out_q[10];
    assign bus.Data_11_Out = out_q[11];
    assign bus.Data_12_Out = out_q[12];
    assign bus.Data_13_Out = out_q[13];
    assign bus.Data_14_Out = out_q[14];
    assign bus.Data_15_Out = out_q[15];
endmodule

// File: tb/tb_demux_1_16_sync.sv
// Self-checking bench for demux_1_16_sync: directed reset/enable/sweep/switch cases
// plus randomized routing compared against a one-line arithmetic reference.
module tb_demux_1_16_sync;
    logic Clock_In;
    logic Reset_N_In;

    int checks = 0;
    int errors = 0;

    demux_1_16_sync_if #(.DATA_WIDTH(1)) bus ();

    demux_1_16_sync #(.DATA_WIDTH(1)) dut (
        .Clock_In   (Clock_In),
        .Reset_N_In (Reset_N_In),
        .bus        (bus)
    );

    initial Clock_In = 1'b0;
    always #5 Clock_In = ~Clock_In;

    logic [15:0] outs;
    assign outs = {bus.Data_15_Out, bus.Data_14_Out, bus.Data_13_Out, bus.Data_12_Out,
                   bus.Data_11_Out, bus.Data_10_Out, bus.Data_9_Out,  bus.Data_8_Out,
                   bus.Data_7_Out,  bus.Data_6_Out,  bus.Data_5_Out,  bus.Data_4_Out,
                   bus.Data_3_Out,  bus.Data_2_Out,  bus.Data_1_Out,  bus.Data_0_Out};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: one destination gets the data bit, everything else is zero.
    function automatic logic [15:0] model(input logic rst_n, input logic en,
                                          input logic d, input int sel);
        if (!rst_n || !en || !d) return 16'h0000;
        return 16'h0001 << sel;
    endfunction

    task automatic drive(input logic en, input logic d, input logic [3:0] sel);
        bus.Enable_In = en;
        bus.Data_In   = d;
        bus.Select_In = sel;
    endtask

    // Clock the currently driven inputs through one edge and compare #1 after it.
    task automatic step(input string tag);
        logic [15:0] exp;
        if (bus.Enable_In && Reset_N_In)
            check({tag, "_sel_known"}, 32'($isunknown(bus.Select_In)), 32'd0);
        exp = model(Reset_N_In, bus.Enable_In, bus.Data_In, int'(bus.Select_In));
        @(posedge Clock_In);
        #1;
        check(tag, 32'(outs), 32'(exp));
        check({tag, "_onehot"}, 32'($countones(outs) <= 1), 32'd1);
    endtask

    initial begin
        Reset_N_In = 1'b0;
        drive(1'b1, 1'b1, 4'd5);
        #1;
        check("reset_initial", 32'(outs), 32'd0);
        repeat (2) step("reset_held");

        Reset_N_In = 1'b1;
        step("reset_release_sel5");
        check("sel5_bit", 32'(bus.Data_5_Out), 32'd1);

        // Asynchronous reset between edges must clear without a clock.
        #2;
        Reset_N_In = 1'b0;
        #1;
        check("async_reset_mid", 32'(outs), 32'd0);
        @(negedge Clock_In);
        Reset_N_In = 1'b1;

        drive(1'b0, 1'b1, 4'd3);
        repeat (2) step("disabled");
        drive(1'b1, 1'b1, 4'd3);
        step("enable_sel3");
        check("sel3_only", 32'(outs), 32'h0008);

        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 4'(k));
            step("sweep_d1");
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 4'(k));
            step("sweep_d0");
        end

        drive(1'b1, 1'b1, 4'd7);
        step("switch_7");
        check("switch_7_val", 32'(outs), 32'h0080);
        drive(1'b1, 1'b1, 4'd8);
        step("switch_8");
        check("switch_8_val", 32'(outs), 32'h0100);

        drive(1'b1, 1'b1, 4'hF);
        step("boundary_15");
        check("boundary_15_bit", 32'(bus.Data_15_Out), 32'd1);
        drive(1'b1, 1'b1, 4'h0);
        step("boundary_0");
        check("boundary_0_val", 32'(outs), 32'h0001);

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step("random_en");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step("random_mixed");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/demux_1_16_sync.md
Name: demux_1_16_sync

Overview:
Registered 1:16 demultiplexer. Routes a single data input to one of sixteen outputs, chosen by a 4-bit select. All other outputs are driven to zero. Used wherever one serial/control bit must be steered to one of 16 consumers with a clean, glitch-free, clock-aligned output.

Parameters:
DATA_WIDTH, 1, width of Data_In and of each Data_k_Out (default single bit).

Ports:
Clock_In  input  1  system clock; all state updates on its rising edge.
Reset_N_In  input  1  asynchronous, active-low reset.
Enable_In  input  1  routing enable; when low, all outputs are driven to zero on the next edge.
Data_In  input  DATA_WIDTH  data to be steered.
Select_In  input  4  destination index, 0..15.
Data_0_Out .. Data_15_Out  output  DATA_WIDTH each  sixteen routed outputs, all registered.

Interface note: one clock, Clock_In. Reset_N_In is asynchronous and active-low.

Behaviour:
- Reset: Reset_N_In low forces all sixteen outputs to 0 immediately, without waiting for a clock edge. Outputs stay 0 while reset is held. Release is synchronous to the design; the first update occurs on the first rising edge after deassertion.
- Each rising edge with Reset_N_In high and Enable_In = 1:
  - Data_k_Out <= Data_In for k == Select_In.
  - Data_j_Out <= 0 for all j != Select_In.
- Each rising edge with Enable_In = 0: all outputs <= 0, regardless of Data_In and Select_In.
- Latency: exactly 1 clock from a stable Enable_In/Select_In/Data_In to the outputs. No combinational path from inputs to outputs.
- At most one output can be non-zero in any cycle (one-hot-or-zero invariant). It is zero-hot when Data_In = 0.
- Select change between cycles: the previous destination returns to 0 on the same edge the new destination takes Data_In. No overlap cycle, no gap cycle.
- Select_In covers all 16 codes. There is no out-of-range case. Select_In = 4'hF drives Data_15_Out.
- Reset asserted mid-operation overrides everything, including the current cycle's enable. Outputs go to 0 asynchronously.
- No handshake, no backpressure, no internal FSM. State is the 16 output registers only.
- X/Z on Select_In while enabled is illegal stimulus. The behaviour is not guaranteed, and the bench flags it.

Decomposition:
- Shared package demux_pkg:
  - localparam SEL_WIDTH = 4
  - localparam NUM_OUTPUTS = 16
  - typedef logic [SEL_WIDTH-1:0] demux_sel_t
- One natural sub-module, decoder_4_16: a combinational 4-to-16 one-hot decoder with an enable input.
  - The top level ANDs each decoder line with Data_In.
  - It registers the 16 results in an always_ff block with asynchronous active-low reset.
  - It fans the register vector out to the sixteen named output ports.

Test Plan:
- Reset: hold Reset_N_In = 0 with Enable_In = 1, Data_In = 1, Select_In = 5, and toggle the clock -> all Data_k_Out = 0. Assert reset between edges while Data_5_Out = 1 -> Data_5_Out drops to 0 before the next edge.
- Disable: Enable_In = 0, Data_In = 1, Select_In = 3 for 2 cycles -> all outputs 0. Set Enable_In = 1 -> Data_3_Out = 1 one edge later, all others 0.
- Full sweep: Enable_In = 1, Data_In = 1, Select_In = 0..15 in consecutive cycles -> exactly Data_k_Out = 1 one cycle after Select_In = k. Repeat with Data_In = 0 -> all outputs 0 every cycle.
- Switching: Select_In goes 7 -> 8 on consecutive cycles with Data_In = 1 -> Data_7_Out falls and Data_8_Out rises on the same edge. Never are both 1, and there is no cycle with both 0.
- Random: after reset, 20 cycles of random Data_In and Select_In with Enable_In = 1 -> each cycle the scoreboard checks output[Select_in_prev] == Data_in_prev and all other outputs are 0.
- Boundary: Select_In = 4'hF with Data_In = 1 -> only Data_15_Out = 1. Select_In = 0 -> only Data_0_Out = 1.
